// File: rtl/matrix_ctrl_pkg.sv
// Shared types and helpers for the matrix read controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   state_t     - controller FSM states
//   total_elems - element count of an N x N matrix
package matrix_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    GAP   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int total_elems(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/matrix_mem.sv
// Synchronous-read ROM holding the matrix; word i holds i mod 2**data_width.
// Latency: 1 cycle from rd_en/rd_addr to rd_data.
// Backpressure: none; rd_data holds its value whenever rd_en is low.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears rd_data)
//   rd_en     - capture the word at rd_addr on this edge
//   rd_addr   - word index
//   rd_data   - registered read data
module matrix_mem #(
  parameter int idx_width  = 6,
  parameter int data_width = 8,
  parameter int depth      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [idx_width-1:0]  rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] rom [depth];

  // Contents are a pure function of the index, so they are built as
  // constant logic rather than loaded from a file.
  always_comb begin
    for (int i = 0; i < depth; i++) begin
      rom[i] = data_width'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rom[rd_addr];
    end
  end

endmodule

// File: rtl/matrix_controller.sv
// Row-major burst reader streaming every element of an N x N matrix as addr/data beats.
// Latency: first out_valid one edge after the edge that moves IDLE->READ; each issued address appears one cycle later.
// Backpressure: none from downstream; enable=0 freezes FSM, counters and pipeline and forces out_valid low.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   enable     - global run enable
//   start      - level request for a full matrix read (must drop before a re-trigger)
//   out_addr   - linear element address of the current beat
//   out_data   - element data aligned with out_addr
//   out_valid  - out_addr/out_data valid this cycle (registered)
// Build option: define CHUNK_GAP_EN to insert one idle cycle between chunks.
module matrix_controller
  import matrix_ctrl_pkg::*;
#(
  parameter int addr_width  = 8,
  parameter int data_width  = 8,
  parameter int chunk_size  = 4,
  parameter int matrix_size = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  output logic [addr_width-1:0] out_addr,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid
);

  localparam int TOTAL = total_elems(matrix_size);
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW    = (chunk_size > 1) ? $clog2(chunk_size) : 1;

  localparam logic [addr_width-1:0] LAST_ADDR  = addr_width'(TOTAL - 1);
  localparam logic [CW-1:0]         CHUNK_LAST = CW'(chunk_size - 1);

  state_t                state_q;
  state_t                state_d;
  logic [addr_width-1:0] addr_cnt;
  logic [CW-1:0]         chunk_cnt;
  logic                  issue;
  logic                  clr_cnt;
  logic                  rd_en;

  // ---------------------------------------------------------------
  // FSM state register; everything freezes while enable is low.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // Next state. 'issue' depends on state only, so out_valid has no
  // path from the inputs beyond the enable gate on its register.
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    clr_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          clr_cnt = 1'b1;
        end
      end
      READ: begin
        issue = 1'b1;
        if (addr_cnt == LAST_ADDR) begin
          state_d = FLUSH;
        end
`ifdef CHUNK_GAP_EN
        else if (chunk_cnt == CHUNK_LAST) begin
          state_d = GAP;
        end
`endif
      end
      GAP: begin
        state_d = READ;
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        // Level start: wait for it to drop so a held request reads once.
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Address and chunk counters. Without the gap option the chunk
  // counter only tracks burst position for observation.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt  <= '0;
      chunk_cnt <= '0;
    end else if (enable) begin
      if (clr_cnt) begin
        addr_cnt  <= '0;
        chunk_cnt <= '0;
      end else if (issue) begin
        addr_cnt  <= addr_cnt + 1'b1;
        chunk_cnt <= (chunk_cnt == CHUNK_LAST) ? '0 : chunk_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Output stage. out_addr is captured on the same edge the ROM
  // captures its word, which keeps address and data aligned through
  // stalls.
  // ---------------------------------------------------------------
  assign rd_en = enable & issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_addr  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_en;
      if (rd_en) begin
        out_addr <= addr_cnt;
      end
    end
  end

  matrix_mem #(
    .idx_width  (IW),
    .data_width (data_width),
    .depth      (TOTAL)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (addr_cnt[IW-1:0]),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_matrix_controller.sv
// Directed self-checking bench for matrix_controller with default parameters.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_matrix_controller;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       start;
  logic [7:0] out_addr;
  logic [7:0] out_data;
  logic       out_valid;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CHUNK_GAP_EN
  localparam bit GAP_EN        = 1'b1;
  localparam int STREAM_CYCLES = 79;
`else
  localparam bit GAP_EN        = 1'b0;
  localparam int STREAM_CYCLES = 64;
`endif

  matrix_controller #(
    .addr_width  (8),
    .data_width  (8),
    .chunk_size  (4),
    .matrix_size (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects start to have just been raised (before the next edge).
  task automatic run_stream(input string tag);
    int exp_addr;
    bit exp_vld;
    tick();
    chk({tag, "_start_edge_vld"}, 32'(out_valid), 32'd0);
    for (int c = 0; c < STREAM_CYCLES; c++) begin
      tick();
      if (GAP_EN) begin
        exp_vld  = (c % 5) != 4;
        exp_addr = (c / 5) * 4 + (c % 5);
      end else begin
        exp_vld  = 1'b1;
        exp_addr = c;
      end
      chk({tag, "_vld"}, 32'(out_valid), 32'(exp_vld));
      if (exp_vld) begin
        chk({tag, "_addr"}, 32'(out_addr), 32'(exp_addr));
        chk({tag, "_data"}, 32'(out_data), 32'(exp_addr % 256));
      end
    end
    tick();
    chk({tag, "_after_vld"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int  e;
    bit  stalled;

    rst    = 1'b1;
    enable = 1'b0;
    start  = 1'b0;

    // Reset held two cycles.
    repeat (2) begin
      tick();
      chk("reset_vld",  32'(out_valid), 32'd0);
      chk("reset_addr", 32'(out_addr),  32'd0);
      chk("reset_data", 32'(out_data),  32'd0);
    end

    // Idle with start low.
    rst    = 1'b0;
    enable = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_vld",  32'(out_valid), 32'd0);
      chk("idle_addr", 32'(out_addr),  32'd0);
    end

    // Full read with start held, then no restart while start stays high.
    start = 1'b1;
    run_stream("full");
    repeat (8) begin
      tick();
      chk("held_start_vld", 32'(out_valid), 32'd0);
    end
    chk("held_start_addr", 32'(out_addr), 32'd63);

    // Re-trigger: drop start one cycle, raise again.
    start = 1'b0;
    tick();
    chk("retrig_low_vld", 32'(out_valid), 32'd0);
    start = 1'b1;
    run_stream("retrig");
    start = 1'b0;
    tick();

    // Enable stall of three cycles right after beat 10.
    start   = 1'b1;
    tick();
    start   = 1'b0;
    e       = 0;
    stalled = 1'b0;
    for (int i = 0; i < 300 && e < 64; i++) begin
      tick();
      if (out_valid) begin
        chk("stall_addr", 32'(out_addr), 32'(e));
        chk("stall_data", 32'(out_data), 32'(e % 256));
        e++;
        if (e == 11 && !stalled) begin
          stalled = 1'b1;
          enable  = 1'b0;
          repeat (3) begin
            tick();
            chk("stall_gap_vld", 32'(out_valid), 32'd0);
          end
          enable = 1'b1;
        end
      end
    end
    chk("stall_hit",   32'(stalled), 32'd1);
    chk("stall_beats", 32'(e),       32'd64);
    repeat (4) tick();
    chk("stall_done_vld", 32'(out_valid), 32'd0);

    // Reset in the middle of a read, right after beat 20.
    start = 1'b1;
    tick();
    e = 0;
    for (int i = 0; i < 200 && e <= 20; i++) begin
      tick();
      if (out_valid) begin
        chk("midrst_addr", 32'(out_addr), 32'(e));
        e++;
      end
    end
    chk("midrst_reached", 32'(e), 32'd21);
    rst = 1'b1;
    tick();
    chk("midrst_vld",  32'(out_valid), 32'd0);
    chk("midrst_addr0", 32'(out_addr), 32'd0);
    chk("midrst_data0", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();
    chk("postrst_start_vld", 32'(out_valid), 32'd0);
    tick();
    chk("postrst_first_vld",  32'(out_valid), 32'd1);
    chk("postrst_first_addr", 32'(out_addr),  32'd0);
    chk("postrst_first_data", 32'(out_data),  32'd0);
    repeat (90) tick();
    chk("postrst_done_vld", 32'(out_valid), 32'd0);
    start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
